// File: rtl/param_sram_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter.
//   state_t   : arbiter FSM states (IDLE, SERVE, CLEAR)
//   LOADER    : requester index of the loader port
//   COMPUTE   : requester index of the compute port
//   rsp_tag_t : one entry of the read-response tracking pipeline
package param_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        CLEAR
    } state_t;

    localparam int unsigned LOADER  = 0;
    localparam int unsigned COMPUTE = 1;

    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/param_sram_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   valid : request lines, bit r = requester r
//   ptr   : index of the requester granted most recently
//   grant : one-hot grant (all zero when nothing is requested)
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        // On contention favour whichever requester was not granted last.
        if (valid == 2'b11) begin
            grant = ptr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/param_sram_arbiter.sv
// Arbitrates a loader and a compute requester onto one synchronous SRAM port
// and can zero-fill the first WORDS entries on demand.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/ready     : per-requester handshake (accept = valid & ready)
//   req_we/addr/wdata   : per-requester command fields
//   rsp_valid, rsp_rdata: per-requester read response, shared data bus
//   clear_start/busy    : zero-fill trigger and in-progress flag
//   mem_*               : SRAM command port (mem_W_req is active-low write)
//   mem_R_data          : SRAM read data, valid one cycle after a read command
module param_sram_arbiter
    import param_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   mem_cs,
    output logic                   mem_oe,
    output logic                   mem_W_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_W_data,
    input  logic [DATA_W-1:0]      mem_R_data
);

    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic [1:0]       grant;
    logic [1:0]       accept;
    logic             acc_any;
    logic             acc_id;
    logic [CNT_W-1:0] clr_cnt;
    logic             clr_last;
    rsp_tag_t         rsp_pipe [2];

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign accept   = req_valid & req_ready;
    assign acc_any  = |accept;
    assign acc_id   = accept[COMPUTE];
    assign clr_last = (clr_cnt == CNT_W'(WORDS - 1));

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: state_nxt = clear_start ? CLEAR : SERVE;
            SERVE: begin
                req_ready = grant;
                if (clear_start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = SERVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Commands are registered, so an accept in the cycle clear_start arrives
    // is driven the cycle the FSM enters CLEAR; sweep writes register behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b1;
            clr_cnt     <= '0;
            mem_cs      <= 1'b0;
            mem_W_req   <= 1'b1;
            mem_addr    <= '0;
            mem_W_data  <= '0;
            rsp_pipe[0] <= '0;
            rsp_pipe[1] <= '0;
        end else begin
            state <= state_nxt;
            if (acc_any) begin
                ptr <= acc_id;
            end

            if (acc_any) begin
                mem_cs     <= 1'b1;
                mem_addr   <= req_addr[acc_id];
                mem_W_req  <= ~req_we[acc_id];
                mem_W_data <= req_wdata[acc_id];
            end else if (state == CLEAR) begin
                mem_cs     <= 1'b1;
                mem_addr   <= ADDR_W'(clr_cnt);
                mem_W_req  <= 1'b0;
                mem_W_data <= '0;
            end else begin
                mem_cs    <= 1'b0;
                mem_W_req <= 1'b1;
            end

            if (state == CLEAR) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end

            rsp_pipe[0] <= '{valid: acc_any & ~req_we[acc_id], id: acc_id};
            rsp_pipe[1] <= rsp_pipe[0];
        end
    end

    always_comb begin
        rsp_valid          = '0;
        rsp_valid[LOADER]  = rsp_pipe[1].valid & (rsp_pipe[1].id == 1'(LOADER));
        rsp_valid[COMPUTE] = rsp_pipe[1].valid & (rsp_pipe[1].id == 1'(COMPUTE));
    end

    assign mem_oe     = rsp_pipe[1].valid;
    assign rsp_rdata  = mem_R_data;
    assign clear_busy = (state == CLEAR);

endmodule
